// File: rtl/memc_dma_responder.sv
// Memory-controller side of the per-lane DMA-to-memory interface: arbitrates DMA
// writes and reads onto one single-port word array and returns read data in order.
module memc_dma_responder #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int RDQ_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dma__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__write_address,
  input  logic [DATA_WIDTH-1:0] dma__memc__write_data,
  output logic                  memc__dma__write_ready,
  input  logic                  dma__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__read_address,
  output logic                  memc__dma__read_ready,
  input  logic                  dma__memc__read_pause,
  output logic [DATA_WIDTH-1:0] memc__dma__read_data,
  output logic                  memc__dma__read_data_valid
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(RDQ_DEPTH + 1);
  localparam int PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;

  logic                  last_was_write;
  logic [CNT_W-1:0]      outstanding;
  logic                  read_eligible;
  logic                  write_fire;
  logic                  read_fire;
  logic [IDX_W-1:0]      write_idx;
  logic [IDX_W-1:0]      read_idx;
  logic                  unused_addr_bits;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_valid;

  logic [DATA_WIDTH-1:0] rdq_mem [RDQ_DEPTH];
  logic [PTR_W-1:0]      rdq_wr_ptr;
  logic [PTR_W-1:0]      rdq_rd_ptr;
  logic [CNT_W-1:0]      rdq_count;
  logic                  rdq_push;
  logic                  rdq_pop;

  // Upper address bits are deliberately dropped so addresses wrap on the array.
  assign write_idx        = dma__memc__write_address[IDX_W-1:0];
  assign read_idx         = dma__memc__read_address[IDX_W-1:0];
  assign unused_addr_bits = ^{dma__memc__write_address[ADDR_WIDTH-1:IDX_W],
                              dma__memc__read_address[ADDR_WIDTH-1:IDX_W]};

  // Credit covers words still in the pipeline as well as those queued.
  assign read_eligible = (outstanding < CNT_W'(RDQ_DEPTH));

  assign memc__dma__write_ready = !reset_poweron &&
      !(dma__memc__read_valid && read_eligible && last_was_write);
  assign memc__dma__read_ready  = !reset_poweron && read_eligible &&
      !(dma__memc__write_valid && !last_was_write);

  assign write_fire = dma__memc__write_valid && memc__dma__write_ready;
  assign read_fire  = dma__memc__read_valid && memc__dma__read_ready;

  assign rdq_push = pipe_valid[RD_LATENCY-1];
  assign rdq_pop  = !dma__memc__read_pause && (rdq_count != '0);

  // NOTE: storage arrays carry no reset; contents survive reset_poweron and only
  // the valid/pointer state around them is cleared.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      mem[write_idx] <= dma__memc__write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (read_fire) begin
      pipe_data[0] <= mem[read_idx];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
    if (rdq_push) begin
      rdq_mem[rdq_wr_ptr] <= pipe_data[RD_LATENCY-1];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= read_fire;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      last_was_write <= 1'b0;
    end else if (write_fire) begin
      last_was_write <= 1'b1;
    end else if (read_fire) begin
      last_was_write <= 1'b0;
    end
  end

  // An accept and a pop in the same cycle leave the credit count unchanged.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      outstanding <= '0;
    end else begin
      case ({read_fire, rdq_pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      rdq_wr_ptr <= '0;
      rdq_rd_ptr <= '0;
      rdq_count  <= '0;
    end else begin
      if (rdq_push) begin
        rdq_wr_ptr <= (rdq_wr_ptr == PTR_W'(RDQ_DEPTH - 1)) ? '0 : rdq_wr_ptr + PTR_W'(1);
      end
      if (rdq_pop) begin
        rdq_rd_ptr <= (rdq_rd_ptr == PTR_W'(RDQ_DEPTH - 1)) ? '0 : rdq_rd_ptr + PTR_W'(1);
      end
      case ({rdq_push, rdq_pop})
        2'b10:   rdq_count <= rdq_count + CNT_W'(1);
        2'b01:   rdq_count <= rdq_count - CNT_W'(1);
        default: rdq_count <= rdq_count;
      endcase
    end
  end

  // Output register holds the last word while paused or idle.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      memc__dma__read_data       <= '0;
      memc__dma__read_data_valid <= 1'b0;
    end else if (rdq_pop) begin
      memc__dma__read_data       <= rdq_mem[rdq_rd_ptr];
      memc__dma__read_data_valid <= 1'b1;
    end else begin
      memc__dma__read_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memc_dma_responder.sv
// Self-checking bench for memc_dma_responder: directed corner-case sequences plus
// randomized traffic compared against a queue-based reference model.
module tb_memc_dma_responder;

  localparam int AW    = 24;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int RL    = 2;
  localparam int QD    = 4;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic          write_valid;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_ready;
  logic          read_valid;
  logic [AW-1:0] read_address;
  logic          read_ready;
  logic          read_pause;
  logic [DW-1:0] read_data;
  logic          read_data_valid;

  always #5 clk = ~clk;

  memc_dma_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_LATENCY(RL), .RDQ_DEPTH(QD)
  ) dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .dma__memc__write_valid     (write_valid),
    .dma__memc__write_address   (write_address),
    .dma__memc__write_data      (write_data),
    .memc__dma__write_ready     (write_ready),
    .dma__memc__read_valid      (read_valid),
    .dma__memc__read_address    (read_address),
    .memc__dma__read_ready      (read_ready),
    .dma__memc__read_pause      (read_pause),
    .memc__dma__read_data       (read_data),
    .memc__dma__read_data_valid (read_data_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted reads (pipeline + queue alike),
  // each tagged with the edge it was accepted on.
  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } rd_t;

  logic [DW-1:0] m_mem [DEPTH];
  rd_t           m_q[$];
  bit            m_lww  = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            cyc    = 0;

  logic          obs_wr, obs_rr, obs_valid;
  logic [DW-1:0] obs_data;

  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra, input logic pause,
                      input logic rst);
    logic elig, exp_wr, exp_rr, wfire, rfire, pop, exp_valid;
    rd_t  r;
    write_valid   = wv;
    write_address = wa;
    write_data    = wd;
    read_valid    = rv;
    read_address  = ra;
    read_pause    = pause;
    reset_poweron = rst;
    #2;
    elig   = (m_q.size() < QD);
    exp_wr = !rst && !(rv && elig && m_lww);
    exp_rr = !rst && elig && !(wv && !m_lww);
    check("write_ready", write_ready, exp_wr);
    check("read_ready", read_ready, exp_rr);
    obs_wr = write_ready;
    obs_rr = read_ready;
    wfire  = wv && exp_wr;
    rfire  = rv && exp_rr;
    pop    = !pause && (m_q.size() > 0) && (m_q[0].acc + RL < cyc);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (rst) begin
      m_q.delete();
      m_lww  = 1'b0;
      m_data = '0;
    end else begin
      if (pop) begin
        exp_valid = 1'b1;
        r         = m_q.pop_front();
        m_data    = r.data;
      end
      if (wfire) begin
        m_mem[wa % DEPTH] = wd;
        m_lww             = 1'b1;
      end
      if (rfire) begin
        r.data = m_mem[ra % DEPTH];
        r.acc  = cyc;
        m_q.push_back(r);
        m_lww = 1'b0;
      end
    end
    cyc++;
    check("read_data_valid", read_data_valid, exp_valid);
    check("read_data", read_data, m_data);
    obs_valid = read_data_valid;
    obs_data  = read_data;
  endtask

  task automatic idle(input logic pause);
    step(1'b0, '0, '0, 1'b0, '0, pause, 1'b0);
  endtask

  typedef struct {
    logic          wv;
    logic          rv;
    logic          pause;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_wr;
    logic          exp_rr;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[8];
    logic [2:0]    lat_bits;
    logic [4:0]    rel_bits;
    logic [6:0]    tog_bits;
    logic          tog_pause [7];
    logic          cred_rr   [6];
    int            post_rst_valids;
    logic          wv_r, rv_r, ps_r, rst_r;
    logic [AW-1:0] wa_r, ra_r;

    for (int i = 0; i < 8; i++) begin
      vecs[i].wv     = 1'b1;
      vecs[i].rv     = 1'b1;
      vecs[i].pause  = 1'b0;
      vecs[i].addr   = AW'(24'h20 + i / 2);
      vecs[i].data   = 32'hA000_0000 + i;
      vecs[i].exp_wr = (i % 2 == 0);
      vecs[i].exp_rr = (i % 2 == 1);
    end
    cred_rr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tog_pause = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset, then first-word latency.
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("reset_valid", obs_valid, 1'b0);
    check("reset_data", obs_data, 32'h0);
    step(1'b1, 24'h10, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 24'h10, 1'b0, 1'b0);
    lat_bits = '0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      lat_bits = {lat_bits[1:0], obs_valid};
    end
    check("latency_valid_pattern", lat_bits, 3'b001);
    check("latency_data", obs_data, 32'hDEAD_BEEF);

    // Contention: alternating grants, same-index read after write.
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wv, vecs[i].addr, vecs[i].data, vecs[i].rv, vecs[i].addr, vecs[i].pause, 1'b0);
      check("tbl_write_ready", obs_wr, vecs[i].exp_wr);
      check("tbl_read_ready", obs_rr, vecs[i].exp_rr);
    end
    for (int i = 0; i < 6; i++) idle(1'b0);

    // Credit limit under pause.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b1, AW'(24'h20 + i % 4), 1'b1, 1'b0);
      check("credit_read_ready", obs_rr, cred_rr[i]);
    end
    rel_bits = '0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      if (i == 0) check("credit_ready_at_release", obs_rr, 1'b0);
      if (i == 1) check("credit_ready_after_pop", obs_rr, 1'b1);
      rel_bits = {rel_bits[3:0], obs_valid};
    end
    check("credit_release_valids", rel_bits, 5'b11110);

    // Pause toggling with a full queue.
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, AW'(24'h20 + i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    tog_bits = '0;
    for (int i = 0; i < 7; i++) begin
      idle(tog_pause[i]);
      tog_bits = {tog_bits[5:0], obs_valid};
    end
    check("toggle_valids", tog_bits, 7'b0101110);

    // Address wrap.
    step(1'b1, 24'h400, 32'h5, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 24'h0, 1'b0, 1'b0);
    lat_bits = '0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      lat_bits = {lat_bits[1:0], obs_valid};
    end
    check("wrap_valid_pattern", lat_bits, 3'b001);
    check("wrap_data", obs_data, 32'h5);

    // Reset with three reads in flight.
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, AW'(24'h20 + i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    post_rst_valids = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b0);
      if (i == 0) check("ready_after_reset", obs_rr, 1'b1);
      if (obs_valid) post_rst_valids++;
    end
    check("no_valid_after_reset", post_rst_valids, 0);

    // Randomized traffic on a preloaded window of 16 indices.
    for (int k = 0; k < 16; k++) step(1'b1, AW'(k), 32'h1111_0000 + k, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      wv_r  = 1'($urandom_range(0, 1));
      rv_r  = 1'($urandom_range(0, 1));
      ps_r  = ($urandom_range(0, 9) < 4);
      rst_r = ($urandom_range(0, 199) == 0);
      wa_r  = {14'($urandom), 6'd0, 4'($urandom)};
      ra_r  = {14'($urandom), 6'd0, 4'($urandom)};
      step(wv_r, wa_r, $urandom, rv_r, ra_r, ps_r, rst_r);
    end
    for (int i = 0; i < 10; i++) idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
